// File: rtl/alu_hilo_ctrl_pkg.sv
// Shared types for the HI/LO multicycle sequencer: control bundle, ALU function
// codes, FSM state, and class-test macros for multicycle (MC) and HI/LO-hazard (HZ) ops.
package alu_hilo_ctrl_pkg;

  typedef struct packed {
    logic clk;
    logic rst;
  } Util_Control_T;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLL  = 4'd6,
    ALU_SRL  = 4'd7,
    ALU_MUL  = 4'd8,
    ALU_MULU = 4'd9,
    ALU_DIV  = 4'd10,
    ALU_DIVU = 4'd11,
    ALU_MFHI = 4'd12,
    ALU_MFLO = 4'd13,
    ALU_MTHI = 4'd14,
    ALU_MTLO = 4'd15
  } Alu_Func_T;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } Hilo_State_T;

endpackage

`ifndef ALU_HILO_CLASS_MACROS
`define ALU_HILO_CLASS_MACROS
`define ALU_IS_MC(f) ((f) inside {ALU_MUL, ALU_MULU, ALU_DIV, ALU_DIVU})
`define ALU_IS_HZ(f) (`ALU_IS_MC(f) || ((f) inside {ALU_MFHI, ALU_MFLO, ALU_MTHI, ALU_MTLO}))
`endif

// File: rtl/alu_hilo_lat_counter.sv
// Loadable latency down-counter with zero flag; clear has priority over load.
module alu_hilo_lat_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/alu_hilo_ctrl.sv
// HI/LO multicycle sequencer: launches mul/div, times completion, interlocks HI/LO users.
// Optional stall statistics counter enabled by defining ALU_HILO_CTRL_STATS_EN.
module alu_hilo_ctrl
  import alu_hilo_ctrl_pkg::*;
#(
  parameter int DELAY     = 2,
  parameter int DIV_DELAY = 4,
  parameter int CNT_W     = $clog2(((DELAY > DIV_DELAY) ? DELAY : DIV_DELAY) + 1)
) (
  input  Util_Control_T ctrl,
  input  logic          in_valid,
  input  Alu_Func_T     in_func,
  output logic          in_ready,
  input  logic          flush,
  output logic          op_start,
  output logic          op_div,
  output logic          hilo_we,
  output logic          busy
`ifdef ALU_HILO_CTRL_STATS_EN
  ,
  output logic [31:0]   stall_cnt
`endif
);

  localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(DELAY - 1);
  localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_DELAY - 1);

  Hilo_State_T state_q, state_d;
  logic        is_mc, is_hz, is_div, cnt_zero;

  assign is_mc  = `ALU_IS_MC(in_func);
  assign is_hz  = `ALU_IS_HZ(in_func);
  assign is_div = (in_func == ALU_DIV) || (in_func == ALU_DIVU);

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    op_start = 1'b0;
    op_div   = 1'b0;
    hilo_we  = 1'b0;
    busy     = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = !ctrl.rst && !flush;
        op_start = in_ready && in_valid && is_mc;
        op_div   = op_start && is_div;
        if (op_start) state_d = RUN;
      end
      RUN: begin
        busy     = 1'b1;
        // HZ ops wait until the cycle after completion; pass-through ops flow freely
        in_ready = !ctrl.rst && !flush && !(in_valid && is_hz);
        hilo_we  = cnt_zero && !flush && !ctrl.rst;
        if (flush || cnt_zero) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ctrl.clk) begin
    if (ctrl.rst) state_q <= IDLE;
    else          state_q <= state_d;
  end

  alu_hilo_lat_counter #(
    .CNT_W(CNT_W)
  ) u_lat_counter (
    .clk_i     (ctrl.clk),
    .clr_i     (ctrl.rst || flush),
    .load_i    (op_start),
    .load_val_i(is_div ? DIV_LD : MUL_LD),
    .dec_i     (busy),
    .zero_o    (cnt_zero)
  );

`ifdef ALU_HILO_CTRL_STATS_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (in_valid && !in_ready && !flush && (stall_q != 32'hFFFF_FFFF))
      stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge ctrl.clk) begin
    if (ctrl.rst) stall_q <= '0;
    else          stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_alu_hilo_ctrl.sv
// Self-checking bench for alu_hilo_ctrl (DELAY=2, DIV_DELAY=4): cycle-level model plus directed literals.
module tb_alu_hilo_ctrl;
  import alu_hilo_ctrl_pkg::*;

  localparam int DLY  = 2;
  localparam int DDLY = 4;

  logic          clk = 1'b0;
  logic          rst;
  Util_Control_T ctrl;
  logic          in_valid, flush;
  Alu_Func_T     in_func;
  logic          in_ready, op_start, op_div, hilo_we, busy;
`ifdef ALU_HILO_CTRL_STATS_EN
  logic [31:0]   stall_cnt;
`endif

  assign ctrl = '{clk: clk, rst: rst};
  always #5 clk = ~clk;

  alu_hilo_ctrl #(.DELAY(DLY), .DIV_DELAY(DDLY)) dut (
    .ctrl    (ctrl),
    .in_valid(in_valid),
    .in_func (in_func),
    .in_ready(in_ready),
    .flush   (flush),
    .op_start(op_start),
    .op_div  (op_div),
    .hilo_we (hilo_we),
    .busy    (busy)
`ifdef ALU_HILO_CTRL_STATS_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  function automatic void chk(string name, longint act, longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endfunction

  function automatic bit f_mc(Alu_Func_T f);
    return f == ALU_MUL || f == ALU_MULU || f == ALU_DIV || f == ALU_DIVU;
  endfunction
  function automatic bit f_hz(Alu_Func_T f);
    return f_mc(f) || f == ALU_MFHI || f == ALU_MFLO || f == ALU_MTHI || f == ALU_MTLO;
  endfunction

  // Model: an in-flight op is just "the cycle it must retire on".
  int     cyc      = 0;
  bit     inflight = 0;
  int     done_at  = 0;
  longint stalls   = 0;

  always @(negedge clk) begin
    bit active, e_rdy, e_start, e_we;
    active  = inflight && (cyc <= done_at);
    e_rdy   = !rst && !flush && !(active && in_valid && f_hz(in_func));
    e_start = e_rdy && in_valid && f_mc(in_func);
    e_we    = active && (cyc == done_at) && !flush && !rst;
    chk("m_in_ready", in_ready, e_rdy);
    chk("m_op_start", op_start, e_start);
    chk("m_op_div", op_div, e_start && (in_func == ALU_DIV || in_func == ALU_DIVU));
    chk("m_hilo_we", hilo_we, e_we);
    chk("m_busy", busy, active);
    chk("m_start_we_excl", op_start && hilo_we, 0);
`ifdef ALU_HILO_CTRL_STATS_EN
    chk("m_stall_cnt", stall_cnt, stalls);
`endif
    if (rst) stalls = 0;
    else if (in_valid && !e_rdy && !flush && stalls != 64'hFFFF_FFFF) stalls++;
    if (rst || flush) inflight = 0;
    else if (e_start) begin
      inflight = 1;
      done_at  = cyc + ((in_func == ALU_DIV || in_func == ALU_DIVU) ? DDLY : DLY);
    end else if (active && cyc == done_at) inflight = 0;
    cyc++;
  end

  // One cycle of stimulus with hand-computed expectations (-1 = don't care).
  task automatic step(input bit v, input Alu_Func_T f, input bit fl, input bit r,
                      input int x_rdy, input int x_st, input int x_div, input int x_we,
                      input int x_bsy, input string tag);
    in_valid = v; in_func = f; flush = fl; rst = r;
    @(negedge clk);
    if (x_rdy >= 0) chk({tag, "_in_ready"}, in_ready, x_rdy);
    if (x_st  >= 0) chk({tag, "_op_start"}, op_start, x_st);
    if (x_div >= 0) chk({tag, "_op_div"}, op_div, x_div);
    if (x_we  >= 0) chk({tag, "_hilo_we"}, hilo_we, x_we);
    if (x_bsy >= 0) chk({tag, "_busy"}, busy, x_bsy);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1: reset
    step(0, ALU_ADD, 0, 1,  0, 0, -1, 0, -1, "t1r0");
    step(0, ALU_ADD, 0, 1,  0, 0, -1, 0,  0, "t1r1");
    step(0, ALU_ADD, 0, 0,  1, 0,  0, 0,  0, "t1a");
    step(0, ALU_ADD, 0, 0,  1, 0,  0, 0,  0, "t1b");
    // 2: Mulu latency
    step(1, ALU_MULU, 0, 0, 1, 1, 0, 0, 0, "t2c0");
    step(0, ALU_ADD,  0, 0, 1, 0, 0, 0, 1, "t2c1");
    step(0, ALU_ADD,  0, 0, 1, 0, 0, 1, 1, "t2c2");
    step(0, ALU_ADD,  0, 0, 1, 0, 0, 0, 0, "t2c3");
    // 3: Mfhi stalls until retire
    step(1, ALU_MULU, 0, 0, 1, 1, 0, 0, 0, "t3c0");
    step(1, ALU_MFHI, 0, 0, 0, 0, 0, 0, 1, "t3c1");
    step(1, ALU_MFHI, 0, 0, 0, 0, 0, 1, 1, "t3c2");
    step(1, ALU_MFHI, 0, 0, 1, 0, 0, 0, 0, "t3c3");
    step(0, ALU_ADD,  0, 0, 1, 0, 0, 0, 0, "t3c4");
`ifdef ALU_HILO_CTRL_STATS_EN
    chk("t3_stall_cnt", stall_cnt, 2);
`endif
    // 4: pass-through op accepted while busy
    step(1, ALU_MULU, 0, 0, 1, 1, 0, 0, 0, "t4c0");
    step(1, ALU_ADD,  0, 0, 1, 0, 0, 0, 1, "t4c1");
    step(0, ALU_ADD,  0, 0, 1, 0, 0, 1, 1, "t4c2");
    step(0, ALU_ADD,  0, 0, 1, 0, 0, 0, 0, "t4c3");
    // 5: Divu flushed mid-flight
    step(1, ALU_DIVU, 0, 0, 1, 1, 1, 0, 0, "t5c0");
    step(0, ALU_ADD,  0, 0, 1, 0, 0, 0, 1, "t5c1");
    step(0, ALU_ADD,  1, 0, 0, 0, 0, 0, 1, "t5c2");
    step(1, ALU_MFLO, 0, 0, 1, 0, 0, 0, 0, "t5c3");
    step(0, ALU_ADD,  0, 0, 1, 0, 0, 0, 0, "t5c4");
    step(0, ALU_ADD,  0, 0, 1, 0, 0, 0, 0, "t5c5");
    step(0, ALU_ADD,  0, 0, 1, 0, 0, 0, 0, "t5c6");
    // flush in the completion cycle suppresses hilo_we; flush in IDLE blocks MC
    step(1, ALU_MUL,  0, 0, 1, 1, 0, 0, 0, "tfc0");
    step(0, ALU_ADD,  0, 0, 1, 0, 0, 0, 1, "tfc1");
    step(0, ALU_ADD,  1, 0, 0, 0, 0, 0, 1, "tfc2");
    step(1, ALU_DIV,  1, 0, 0, 0, 0, 0, 0, "tfc3");
    step(0, ALU_ADD,  0, 0, 1, 0, 0, 0, 0, "tfc4");
    // 6: reset aborts Div, then Mul runs normally
    step(1, ALU_DIV,  0, 0, 1, 1, 1, 0, 0, "t6c0");
    step(0, ALU_ADD,  0, 0, 1, 0, 0, 0, 1, "t6c1");
    step(0, ALU_ADD,  0, 1, 0, 0, 0, 0, -1, "t6c2");
    step(0, ALU_ADD,  0, 1, 0, 0, 0, 0, 0, "t6c3");
    step(1, ALU_MUL,  0, 0, 1, 1, 0, 0, 0, "t6c4");
    step(0, ALU_ADD,  0, 0, 1, 0, 0, 0, 1, "t6c5");
    step(0, ALU_ADD,  0, 0, 1, 0, 0, 1, 1, "t6c6");
    step(0, ALU_ADD,  0, 0, 1, 0, 0, 0, 0, "t6c7");
    // HZ writer (Mthi) and MC both stall while Div runs, accepted after retire
    step(1, ALU_DIV,  0, 0, 1, 1, 1, 0, 0, "t7c0");
    step(1, ALU_MTHI, 0, 0, 0, 0, 0, 0, 1, "t7c1");
    step(1, ALU_MUL,  0, 0, 0, 0, 0, 0, 1, "t7c2");
    step(1, ALU_MTLO, 0, 0, 0, 0, 0, 0, 1, "t7c3");
    step(1, ALU_MUL,  0, 0, 0, 0, 0, 1, 1, "t7c4");
    step(1, ALU_MUL,  0, 0, 1, 1, 0, 0, 0, "t7c5");
    step(0, ALU_ADD,  0, 0, 1, 0, 0, 0, 1, "t7c6");
    step(0, ALU_ADD,  0, 0, 1, 0, 0, 1, 1, "t7c7");
    step(0, ALU_ADD,  0, 0, 1, 0, 0, 0, 0, "t7c8");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
